alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Front-end controller that drives the wide ALU's operand/opcode inputs and collects its RESULT/FLAGS outputs. It accepts one operation at a time over a valid/ready command port and registers the operands and opcode onto the ALU inputs. It waits a fixed settle time for the combinational ALU to resolve, then captures the result and flags. The captured values are returned over a valid/ready response port, with a completion counter and sticky flag summary for the surrounding datapath.

Parameters:
N, 256, operand/result width; must equal the ALU's N
SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture; legal range 1..15
CNT_W, 16, width of completion counter

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept command
CMD_A  in  N  operand A
CMD_B  in  N  operand B
CMD_OP  in  3  opcode: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll, 7 srl, 0 no-op (ALU returns zeros)
ALU_A  out  N  registered operand to ALU A
ALU_B  out  N  registered operand to ALU B
ALU_UC  out  3  registered opcode to ALU UC
ALU_RESULT  in  N  ALU RESULT
ALU_FLAGS  in  4  ALU FLAGS
RSP_VALID  out  1  response present
RSP_READY  in  1  consumer accepts response
RSP_RESULT  out  N  captured result
RSP_FLAGS  out  4  captured flags
RSP_OP  out  3  opcode that produced the response
BUSY  out  1  high in SETTLE or RESP
OP_COUNT  out  CNT_W  completed response transfers
STICKY_FLAGS  out  4  OR of all captured flags since reset/clear
CLR_STICKY  in  1  one-cycle clear of STICKY_FLAGS

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE. ALU_A, ALU_B, ALU_UC, RSP_RESULT, RSP_FLAGS, RSP_OP, OP_COUNT and STICKY_FLAGS = 0. RSP_VALID = 0, BUSY = 0.
- Reset mid-operation: the in-flight command is dropped and no response is issued. rst overrides every other input.
- FSM states: IDLE, SETTLE, RESP.
- CMD_READY = (state==IDLE) | (state==RESP & RSP_READY). This is combinational from RSP_READY.
- Accept: a command is accepted at an edge with CMD_VALID & CMD_READY.
  - On accept, ALU_A/ALU_B/ALU_UC <= CMD_A/CMD_B/CMD_OP, settle counter <= SETTLE_CYCLES-1, and state <= SETTLE.
- SETTLE: each edge, if cnt != 0 then cnt--. If cnt == 0, capture:
  - RSP_RESULT <= ALU_RESULT, RSP_FLAGS <= ALU_FLAGS, RSP_OP <= ALU_UC.
  - RSP_VALID <= 1, state <= RESP.
- CMD_VALID is ignored in SETTLE; commands are never queued.
- Latency: with accept at edge E0, capture occurs at edge E0+SETTLE_CYCLES and RSP_VALID is high in the following cycle. With the default of 2, accept at E0 gives RSP_VALID after E2.
- RESP: RSP_* are held stable while RSP_VALID & !RSP_READY; backpressure is unbounded.
  - Transfer edge (RSP_VALID & RSP_READY): OP_COUNT++ (wraps all-ones -> 0). Then either:
    - if CMD_VALID is also high, accept the new command in the same edge (state SETTLE, RSP_VALID <= 0);
    - otherwise state IDLE, RSP_VALID <= 0.
  - Minimum spacing between accepts is SETTLE_CYCLES+1 cycles.
- ALU_A/ALU_B/ALU_UC hold the last accepted command's values until the next accept; they never return to 0 except on reset.
- STICKY_FLAGS:
  - Capture edge: STICKY_FLAGS <= STICKY_FLAGS | ALU_FLAGS.
  - CLR_STICKY alone: STICKY_FLAGS <= 0.
  - CLR_STICKY and capture in the same edge: STICKY_FLAGS <= ALU_FLAGS; the new flags survive the clear.
- BUSY = (state != IDLE).
- The sequencer does not interpret flags or check opcode legality. Opcode 0 passes through as a normal command.

Test Plan:
- Reset: assert rst 2 cycles with CMD_VALID=1 -> all outputs 0, CMD_READY=1 after release, no accept while rst=1.
- Single op with bench ALU stub (ALU_RESULT = ALU_A & ALU_B, ALU_FLAGS = 4'b0100), CMD_A=0xF0, CMD_B=0x3C, CMD_OP=3, accept at E0:
  - ALU_UC=3 after E0; RSP_VALID rises after E2.
  - RSP_RESULT=0x30, RSP_FLAGS=4'b0100, RSP_OP=3, OP_COUNT=1.
- Backpressure: hold RSP_READY=0 for 10 cycles with a new CMD_VALID pending -> RSP_* stable, CMD_READY=0, ALU_* unchanged; raise RSP_READY -> transfer and new accept in the same edge, RSP_VALID low the next cycle.
- Back-to-back: 5 commands with RSP_READY=1 constant -> accept edges spaced exactly 3 cycles apart, OP_COUNT=5, responses in order with matching RSP_OP.
- Sticky flags: capture 4'b0001 then 4'b1000 -> STICKY_FLAGS=4'b1001. Then CLR_STICKY on the capture edge of 4'b0010 -> STICKY_FLAGS=4'b0010.
- Reset mid-op: rst asserted at edge E1 after accept at E0 -> no RSP_VALID ever for that command, ALU_UC=0, OP_COUNT=0. Also preload OP_COUNT to all-ones via 65535 ops (or force) -> next transfer wraps to 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals between the sequencer and its neighbours.
// The sequencer takes the slave view. The master view belongs to the command source, response sink and ALU.
interface alu_cmd_sequencer_if #(
    parameter int N = 256
);
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [N-1:0] CMD_A;
    logic [N-1:0] CMD_B;
    logic [2:0]   CMD_OP;
    logic [N-1:0] ALU_A;
    logic [N-1:0] ALU_B;
    logic [2:0]   ALU_UC;
    logic [N-1:0] ALU_RESULT;
    logic [3:0]   ALU_FLAGS;
    logic         RSP_VALID;
    logic         RSP_READY;
    logic [N-1:0] RSP_RESULT;
    logic [3:0]   RSP_FLAGS;
    logic [2:0]   RSP_OP;

    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_OP, ALU_RESULT, ALU_FLAGS, RSP_READY,
        output CMD_READY, ALU_A, ALU_B, ALU_UC, RSP_VALID, RSP_RESULT, RSP_FLAGS, RSP_OP
    );

    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_OP, ALU_RESULT, ALU_FLAGS, RSP_READY,
        input  CMD_READY, ALU_A, ALU_B, ALU_UC, RSP_VALID, RSP_RESULT, RSP_FLAGS, RSP_OP
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational wide ALU one command at a time.
// It holds the operands for a fixed settle time, then returns the captured result and flags.
module alu_cmd_sequencer #(
    parameter int N             = 256,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_sequencer_if.slave bus,
    input  logic             CLR_STICKY,
    output logic             BUSY,
    output logic [CNT_W-1:0] OP_COUNT,
    output logic [3:0]       STICKY_FLAGS,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [N-1:0]     alu_a_q, alu_b_q, rsp_result_q;
    logic [2:0]       alu_uc_q, rsp_op_q;
    logic [3:0]       rsp_flags_q, sticky_q;
    logic             rsp_valid_q;
    logic [CNT_W-1:0] op_count_q;

    logic cmd_ready, accept, transfer, capture;

    // Handshakes: a transfer happens on any rising edge where VALID and READY are both high.
    // VALID never depends on READY. CMD_READY is combinational from RSP_READY.
    // This lets a response drain and a new command enter on the same edge.
    assign cmd_ready = (state_q == IDLE) || (state_q == RESP && bus.RSP_READY);
    assign accept    = bus.CMD_VALID && cmd_ready;
    assign transfer  = rsp_valid_q && bus.RSP_READY;
    assign capture   = (state_q == SETTLE) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_uc_q     <= 3'd0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'd0;
            rsp_op_q     <= 3'd0;
            rsp_valid_q  <= 1'b0;
            op_count_q   <= '0;
            sticky_q     <= 4'd0;
        end else begin
            if (transfer) op_count_q <= op_count_q + 1'b1;

            // A clear on the capture edge still keeps the freshly captured flags.
            if (capture) sticky_q <= (CLR_STICKY ? 4'd0 : sticky_q) | bus.ALU_FLAGS;
            else if (CLR_STICKY) sticky_q <= 4'd0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q  <= bus.CMD_A;
                        alu_b_q  <= bus.CMD_B;
                        alu_uc_q <= bus.CMD_OP;
                        cnt_q    <= SETTLE_INIT;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_result_q <= bus.ALU_RESULT;
                        rsp_flags_q  <= bus.ALU_FLAGS;
                        rsp_op_q     <= alu_uc_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        if (bus.CMD_VALID) begin
                            alu_a_q  <= bus.CMD_A;
                            alu_b_q  <= bus.CMD_B;
                            alu_uc_q <= bus.CMD_OP;
                            cnt_q    <= SETTLE_INIT;
                            state_q  <= SETTLE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.CMD_READY  = cmd_ready;
    assign bus.ALU_A      = alu_a_q;
    assign bus.ALU_B      = alu_b_q;
    assign bus.ALU_UC     = alu_uc_q;
    assign bus.RSP_VALID  = rsp_valid_q;
    assign bus.RSP_RESULT = rsp_result_q;
    assign bus.RSP_FLAGS  = rsp_flags_q;
    assign bus.RSP_OP     = rsp_op_q;
    assign BUSY           = (state_q != IDLE);
    assign OP_COUNT       = op_count_q;
    assign STICKY_FLAGS   = sticky_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an AND-based ALU stub and controllable flags.
// A narrow completion counter keeps the counter-wrap case short.
module tb_alu_cmd_sequencer;
    localparam int N     = 256;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr_sticky = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [3:0]       sticky;
    logic [1:0]       state_dbg;
    logic [3:0]       stub_flags = 4'd0;

    int checks = 0;
    int errors = 0;

    logic [N+2:0] exp_q[$];

    alu_cmd_sequencer_if #(.N(N)) bus ();

    alu_cmd_sequencer #(.N(N), .SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .CLR_STICKY   (clr_sticky),
        .BUSY         (busy),
        .OP_COUNT     (op_count),
        .STICKY_FLAGS (sticky),
        .state_o      (state_dbg)
    );

    // ALU stub: the result is A AND B. The flags come from a bench variable.
    assign bus.ALU_RESULT = bus.ALU_A & bus.ALU_B;
    assign bus.ALU_FLAGS  = stub_flags;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                         input logic [3:0] flags);
        int n;
        bus.CMD_A = a;
        bus.CMD_B = b;
        bus.CMD_OP = op;
        stub_flags = flags;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        n = 0;
        while (!bus.RSP_VALID && n < 10) begin
            tick();
            n++;
        end
        chk("op_rsp_valid", bus.RSP_VALID, 1);
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
    endtask

    initial begin
        int cyc, sent, got, last_acc;
        logic acc, xfer;
        logic [N+2:0] e;
        logic [N-1:0] a_v, b_v;
        logic [2:0] op_v;

        // Reset with a command pending: nothing may be accepted.
        bus.CMD_VALID = 1'b1;
        bus.CMD_A = 256'h55;
        bus.CMD_B = 256'h66;
        bus.CMD_OP = 3'd5;
        bus.RSP_READY = 1'b0;
        tick();
        tick();
        chk("rst_alu_uc", bus.ALU_UC, 0);
        chk("rst_alu_a", bus.ALU_A, 0);
        chk("rst_rsp_valid", bus.RSP_VALID, 0);
        chk("rst_rsp_result", bus.RSP_RESULT, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_sticky", sticky, 0);
        rst = 1'b0;
        bus.CMD_VALID = 1'b0;
        #1;
        chk("rst_cmd_ready", bus.CMD_READY, 1);

        // Single operation: F0 & 3C = 30, flags 0100.
        bus.CMD_A = 256'hF0;
        bus.CMD_B = 256'h3C;
        bus.CMD_OP = 3'd3;
        stub_flags = 4'b0100;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        chk("e0_alu_uc", bus.ALU_UC, 3);
        chk("e0_busy", busy, 1);
        chk("e0_rsp_valid", bus.RSP_VALID, 0);
        tick();
        chk("e1_rsp_valid", bus.RSP_VALID, 0);
        tick();
        chk("e2_rsp_valid", bus.RSP_VALID, 1);
        chk("e2_rsp_result", bus.RSP_RESULT, 256'h30);
        chk("e2_rsp_flags", bus.RSP_FLAGS, 4'b0100);
        chk("e2_rsp_op", bus.RSP_OP, 3);
        chk("e2_op_count", op_count, 0);
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        chk("single_op_count", op_count, 1);
        chk("single_rsp_valid", bus.RSP_VALID, 0);
        chk("single_busy", busy, 0);

        // Backpressure: response 0F & FF = 0F held while a new command waits.
        bus.CMD_A = 256'h0F;
        bus.CMD_B = 256'hFF;
        bus.CMD_OP = 3'd1;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_A = 256'hAA;
        bus.CMD_B = 256'h0F;
        bus.CMD_OP = 3'd5;
        tick();
        tick();
        chk("bp_rsp_valid", bus.RSP_VALID, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", bus.RSP_VALID, 1);
            chk("bp_hold_result", bus.RSP_RESULT, 256'h0F);
            chk("bp_hold_op", bus.RSP_OP, 1);
            chk("bp_cmd_ready", bus.CMD_READY, 0);
            chk("bp_alu_uc", bus.ALU_UC, 1);
            chk("bp_alu_a", bus.ALU_A, 256'h0F);
        end
        bus.RSP_READY = 1'b1;
        #1;
        chk("bp_cmd_ready_rise", bus.CMD_READY, 1);
        tick();
        bus.RSP_READY = 1'b0;
        bus.CMD_VALID = 1'b0;
        chk("bp_xfer_rsp_valid", bus.RSP_VALID, 0);
        chk("bp_xfer_op_count", op_count, 2);
        chk("bp_new_alu_uc", bus.ALU_UC, 5);
        chk("bp_new_alu_a", bus.ALU_A, 256'hAA);
        chk("bp_new_busy", busy, 1);
        tick();
        tick();
        chk("bp2_rsp_valid", bus.RSP_VALID, 1);
        chk("bp2_rsp_result", bus.RSP_RESULT, 256'h0A);
        chk("bp2_rsp_op", bus.RSP_OP, 5);
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        chk("bp2_op_count", op_count, 3);

        // Back-to-back: five commands, consumer always ready.
        bus.RSP_READY = 1'b1;
        a_v = 256'hF0;
        b_v = 256'h3C;
        op_v = 3'd1;
        bus.CMD_A = a_v;
        bus.CMD_B = b_v;
        bus.CMD_OP = op_v;
        bus.CMD_VALID = 1'b1;
        cyc = 0;
        sent = 0;
        got = 0;
        last_acc = 0;
        while (got < 5 && cyc < 60) begin
            acc = bus.CMD_VALID && bus.CMD_READY;
            xfer = bus.RSP_VALID && bus.RSP_READY;
            if (xfer) begin
                e = exp_q.pop_front();
                chk("b2b_result", bus.RSP_RESULT, e[N-1:0]);
                chk("b2b_op", bus.RSP_OP, e[N+2:N]);
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent > 0) chk("b2b_spacing", cyc - last_acc, 3);
                last_acc = cyc;
                exp_q.push_back({op_v, a_v & b_v});
                sent++;
                if (sent < 5) begin
                    a_v = a_v ^ 256'h1FF;
                    b_v = b_v + 256'h11;
                    op_v = op_v + 3'd1;
                    bus.CMD_A = a_v;
                    bus.CMD_B = b_v;
                    bus.CMD_OP = op_v;
                end else begin
                    bus.CMD_VALID = 1'b0;
                end
            end
            if (xfer) got++;
        end
        bus.RSP_READY = 1'b0;
        chk("b2b_got_all", got, 5);
        chk("b2b_op_count", op_count, 8);
        chk("b2b_busy", busy, 0);

        // Sticky flags.
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_clr", sticky, 0);
        do_op(256'h1, 256'h1, 3'd2, 4'b0001);
        do_op(256'h2, 256'h3, 3'd4, 4'b1000);
        chk("sticky_or", sticky, 4'b1001);
        bus.CMD_A = 256'h7;
        bus.CMD_B = 256'h5;
        bus.CMD_OP = 3'd7;
        stub_flags = 4'b0010;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_clr_capture", sticky, 4'b0010);
        chk("sticky_clr_rsp_valid", bus.RSP_VALID, 1);
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        chk("sticky_op_count", op_count, 11);

        // Reset in the middle of an operation.
        bus.CMD_A = 256'h9;
        bus.CMD_B = 256'h9;
        bus.CMD_OP = 3'd6;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        chk("midrst_alu_uc_pre", bus.ALU_UC, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_alu_uc", bus.ALU_UC, 0);
        chk("midrst_op_count", op_count, 0);
        chk("midrst_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_no_rsp", bus.RSP_VALID, 0);
        end

        // Counter wrap: fifteen ops reach all-ones, the next transfer wraps to zero.
        for (int i = 0; i < 15; i++) do_op(256'(i), 256'hFF, 3'd0, 4'd0);
        chk("wrap_all_ones", op_count, 4'hF);
        do_op(256'h3, 256'h3, 3'd0, 4'd0);
        chk("wrap_zero", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
